// File: rtl/seg_display_sched.sv
// Seven-segment display scheduler: shows score_val by default, lends the display to a
// message requester for HOLD_TICKS cycles. Optional blink feature: `SEG_BLINK_EN.
module seg_display_sched #(
   parameter int unsigned HOLD_TICKS  = 25_000_000,
   parameter int unsigned BLINK_TICKS = 12_500_000,
   parameter int unsigned CNT_W       = 25
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] score_val,
   input  logic        msg_req,
   input  logic [15:0] msg_val,
   input  logic        msg_cancel,
   output logic        msg_ack,
   output logic        msg_done,
   output logic        busy,
   output logic [3:0]  D,
   output logic [3:0]  C,
   output logic [3:0]  B,
   output logic [3:0]  A
);

   typedef enum logic [1:0] {IDLE, SHOW, DONE} state_t;

   localparam int unsigned CNT_MAX = (HOLD_TICKS > BLINK_TICKS) ? HOLD_TICKS : BLINK_TICKS;
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_TICKS - 1);

   // Elaboration-time guard: counters must hold the largest terminal count.
   if (((CNT_MAX - 1) >> CNT_W) != 0) begin : g_bad_cnt_w
      $error("CNT_W too narrow for HOLD_TICKS/BLINK_TICKS");
   end

   state_t             state;
   logic [CNT_W-1:0]   hold_cnt;
   logic [15:0]        msg_reg;
   logic [15:0]        show_val_c;
   logic               hold_end_c;

`ifdef SEG_BLINK_EN
   localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_TICKS - 1);
   logic [CNT_W-1:0]   blink_cnt;
   logic               phase;

   // Phase 1 lets the score through between message flashes.
   always_comb begin
      show_val_c = phase ? score_val : msg_reg;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         blink_cnt <= '0;
         phase     <= 1'b0;
      end else if (state == IDLE && msg_req) begin
         blink_cnt <= '0;
         phase     <= 1'b0;
      end else if (state == SHOW) begin
         if (blink_cnt == BLINK_LAST) begin
            blink_cnt <= '0;
            phase     <= ~phase;
         end else begin
            blink_cnt <= blink_cnt + CNT_W'(1);
         end
      end
   end
`else
   always_comb begin
      show_val_c = msg_reg;
   end
`endif

   always_comb begin
      hold_end_c = (hold_cnt == HOLD_LAST) || msg_cancel;
   end

   // Main FSM with registered handshake and display outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= IDLE;
         hold_cnt     <= '0;
         msg_reg      <= '0;
         msg_ack      <= 1'b0;
         msg_done     <= 1'b0;
         busy         <= 1'b0;
         {D, C, B, A} <= 16'h0000;
      end else begin
         msg_ack  <= 1'b0;
         msg_done <= 1'b0;
         busy     <= (state != IDLE);
         case (state)
            IDLE: begin
               {D, C, B, A} <= score_val;
               if (msg_req) begin
                  msg_ack  <= 1'b1;
                  msg_reg  <= msg_val;
                  hold_cnt <= '0;
                  state    <= SHOW;
               end
            end
            SHOW: begin
               {D, C, B, A} <= show_val_c;
               if (hold_end_c) begin
                  msg_done <= 1'b1;
                  state    <= DONE;
               end else begin
                  hold_cnt <= hold_cnt + CNT_W'(1);
               end
            end
            DONE: begin
               {D, C, B, A} <= score_val;
               state        <= IDLE;
            end
            default: begin
               {D, C, B, A} <= score_val;
               state        <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seg_display_sched.sv
// Directed table-driven bench for seg_display_sched (HOLD_TICKS=8, BLINK_TICKS=2).
module tb_seg_display_sched;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] score_val;
   logic        msg_req;
   logic [15:0] msg_val;
   logic        msg_cancel;
   logic        msg_ack;
   logic        msg_done;
   logic        busy;
   logic [3:0]  D, C, B, A;

   seg_display_sched #(.HOLD_TICKS(8), .BLINK_TICKS(2), .CNT_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .score_val(score_val), .msg_req(msg_req),
      .msg_val(msg_val), .msg_cancel(msg_cancel), .msg_ack(msg_ack),
      .msg_done(msg_done), .busy(busy), .D(D), .C(C), .B(B), .A(A)
   );

   always #5 clk = ~clk;

   // One row per clock: inputs driven during the cycle, outputs expected after its edge.
   typedef struct {
      logic        rst_n;
      logic [15:0] score;
      logic        req;
      logic [15:0] val;
      logic        cancel;
      logic        ack;
      logic        done;
      logic        busy;
      logic [15:0] disp;
   } vec_t;

   vec_t vecs[$];
   int   n_vec = 0;
   int   n_err = 0;

   task automatic add(input logic r, input logic [15:0] s, input logic rq,
                      input logic [15:0] v, input logic cn, input logic ak,
                      input logic dn, input logic by, input logic [15:0] dp);
      vec_t x;
      x.rst_n = r; x.score = s; x.req = rq; x.val = v; x.cancel = cn;
      x.ack = ak; x.done = dn; x.busy = by; x.disp = dp;
      vecs.push_back(x);
   endtask

   // Display expected after SHOW cycle k (hold_cnt==k).
   function automatic logic [15:0] show_exp(input int k, input logic [15:0] m,
                                            input logic [15:0] s);
`ifdef SEG_BLINK_EN
      return (((k / 2) % 2) == 1) ? s : m;
`else
      return m;
`endif
   endfunction

   task automatic check(input string name, input logic [18:0] act, input logic [18:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got ack=%b done=%b busy=%b disp=%h, want ack=%b done=%b busy=%b disp=%h",
                  name, act[18], act[17], act[16], act[15:0], exp[18], exp[17], exp[16], exp[15:0]);
      end
   endtask

   initial begin
      int n;
      rst_n = 1'b0; score_val = 16'h1234; msg_req = 1'b0; msg_val = 16'h0000; msg_cancel = 1'b0;

      // Reset and score follow-through
      add(0, 16'h1234, 0, 16'h0, 0, 0, 0, 0, 16'h0000);
      add(0, 16'h1234, 0, 16'h0, 0, 0, 0, 0, 16'h0000);
      add(1, 16'h1234, 0, 16'h0, 0, 0, 0, 0, 16'h1234);
      add(1, 16'h5678, 0, 16'h0, 0, 0, 0, 0, 16'h5678);
      add(1, 16'h1234, 0, 16'h0, 1, 0, 0, 0, 16'h1234);
      // Full-length message with timeout
      add(1, 16'h1234, 1, 16'hABCD, 0, 1, 0, 0, 16'h1234);
      for (int k = 0; k < 8; k++)
         add(1, 16'h1234, 0, 16'hABCD, 0, 0, (k == 7), 1, show_exp(k, 16'hABCD, 16'h1234));
      add(1, 16'h1234, 0, 16'h0, 0, 0, 0, 1, 16'h1234);
      add(1, 16'h1234, 0, 16'h0, 0, 0, 0, 0, 16'h1234);
      // Cancel on the third SHOW cycle; cancel held into DONE/IDLE has no effect
      add(1, 16'h1234, 1, 16'h0F0F, 0, 1, 0, 0, 16'h1234);
      add(1, 16'h1234, 0, 16'h0, 0, 0, 0, 1, show_exp(0, 16'h0F0F, 16'h1234));
      add(1, 16'h1234, 0, 16'h0, 0, 0, 0, 1, show_exp(1, 16'h0F0F, 16'h1234));
      add(1, 16'h1234, 0, 16'h0, 1, 0, 1, 1, show_exp(2, 16'h0F0F, 16'h1234));
      add(1, 16'h1234, 0, 16'h0, 1, 0, 0, 1, 16'h1234);
      add(1, 16'h1234, 0, 16'h0, 1, 0, 0, 0, 16'h1234);
      add(1, 16'h1234, 0, 16'h0, 0, 0, 0, 0, 16'h1234);
      // Request held through SHOW, msg_val changed mid-message, re-accept after DONE
      add(1, 16'h1234, 1, 16'h1111, 0, 1, 0, 0, 16'h1234);
      for (int k = 0; k < 8; k++)
         add(1, 16'h1234, 1, (k >= 3) ? 16'h9999 : 16'h1111, 0, 0, (k == 7), 1,
             show_exp(k, 16'h1111, 16'h1234));
      add(1, 16'h1234, 1, 16'h2222, 0, 0, 0, 1, 16'h1234);
      add(1, 16'h1234, 1, 16'h2222, 0, 1, 0, 0, 16'h1234);
      add(1, 16'h1234, 0, 16'h0, 1, 0, 1, 1, 16'h2222);
      add(1, 16'h1234, 0, 16'h0, 0, 0, 0, 1, 16'h1234);
      add(1, 16'h1234, 0, 16'h0, 0, 0, 0, 0, 16'h1234);
      // Reset in the middle of SHOW drops the message silently
      add(1, 16'h1234, 1, 16'h7777, 0, 1, 0, 0, 16'h1234);
      add(1, 16'h1234, 0, 16'h0, 0, 0, 0, 1, show_exp(0, 16'h7777, 16'h1234));
      add(1, 16'h1234, 0, 16'h0, 0, 0, 0, 1, show_exp(1, 16'h7777, 16'h1234));
      add(0, 16'h1234, 0, 16'h0, 0, 0, 0, 0, 16'h0000);
      add(1, 16'h4321, 0, 16'h0, 0, 0, 0, 0, 16'h4321);
      for (int k = 0; k < 8; k++)
         add(1, 16'h4321, 0, 16'h0, 0, 0, 0, 0, 16'h4321);

      for (int i = 0; i < vecs.size(); i++) begin
         rst_n = vecs[i].rst_n; score_val = vecs[i].score; msg_req = vecs[i].req;
         msg_val = vecs[i].val; msg_cancel = vecs[i].cancel;
         @(posedge clk); #1;
         check($sformatf("vec%0d", i), {msg_ack, msg_done, busy, D, C, B, A},
               {vecs[i].ack, vecs[i].done, vecs[i].busy, vecs[i].disp});
      end

      // Hand sequence: ack-to-done distance equals HOLD_TICKS, single done pulse
      score_val = 16'h1234; msg_req = 1'b1; msg_val = 16'hCAFE; msg_cancel = 1'b0;
      @(posedge clk); #1;
      check("hold_ack", {msg_ack, msg_done, busy, D, C, B, A}, {1'b1, 1'b0, 1'b0, 16'h1234});
      msg_req = 1'b0;
      n = 0;
      while (n < 40) begin
         @(posedge clk); #1;
         n++;
         if (msg_done) break;
      end
      n_vec++;
      if (n != 8) begin
         n_err++;
         $display("FAIL hold_len: got %0d cycles ack->done, want 8", n);
      end
      @(posedge clk); #1;
      check("hold_after", {msg_ack, msg_done, busy, D, C, B, A}, {1'b0, 1'b0, 1'b1, 16'h1234});
      @(posedge clk); #1;
      check("hold_idle", {msg_ack, msg_done, busy, D, C, B, A}, {1'b0, 1'b0, 1'b0, 16'h1234});

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
